// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage hazard inputs, stall/flush/forward controls, perf counters.
// master = pipeline side driving stage info; slave = hazard controller.
interface hazard_ctrl_if;
  logic [4:0]  rs1_addr_D, rs2_addr_D;
  logic [4:0]  rs1_addr_E, rs2_addr_E;
  logic [4:0]  rd_addr_E, rd_addr_M, rd_addr_W;
  logic        rd_wren_E, rd_wren_M, rd_wren_W;
  logic [1:0]  wb_sel_E;
  logic        pc_sel_E;
  logic        mem_req_M;
  logic        mem_ack;
  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic [1:0]  fwd_a_E, fwd_b_E;
  logic        err_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
    output rd_addr_E, rd_addr_M, rd_addr_W, rd_wren_E, rd_wren_M, rd_wren_W,
    output wb_sel_E, pc_sel_E, mem_req_M, mem_ack,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    input  fwd_a_E, fwd_b_E, err_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
    input  rd_addr_E, rd_addr_M, rd_addr_W, rd_wren_E, rd_wren_M, rd_wren_W,
    input  wb_sel_E, pc_sel_E, mem_req_M, mem_ack,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
    output fwd_a_E, fwd_b_E, err_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I five-stage hazard control: load-use, redirect, data-memory wait with timeout, forwarding.
// Controls are combinational in the same cycle; state, wait counter and perf counters update on i_clk.
module hazard_ctrl #(
  parameter logic [1:0] WB_MEM  = 2'b01,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic lu, mw, mem_stall, timeout_rel, redirect;
  logic st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic wr_m,
                                         input logic [4:0] rd_w, input logic wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_stall   = 1'b0;
    timeout_rel = 1'b0;
    redirect    = 1'b0;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_w = 1'b0;

    lu = (hz.wb_sel_E == WB_MEM) && hz.rd_wren_E && (hz.rd_addr_E != 5'd0) &&
         ((hz.rd_addr_E == hz.rs1_addr_D) || (hz.rd_addr_E == hz.rs2_addr_D));
    mw = hz.mem_req_M && !hz.mem_ack;

    case (state_q)
      ST_RUN: begin
        mem_stall = mw;
        if (mw) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = 8'd0;
        end
      end
      default: begin
        if (hz.mem_ack) begin
          state_d = ST_RUN;
        end else if (wcnt_q < TIMEOUT) begin
          mem_stall = 1'b1;
          wcnt_d    = wcnt_q + 8'd1;
        end else begin
          timeout_rel = 1'b1;
          state_d     = ST_RUN;
        end
      end
    endcase

    // Execute is frozen under a memory stall, so redirect/load-use wait for release.
    if (mem_stall) begin
      st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
      fl_w = 1'b1;
    end else if (hz.pc_sel_E) begin
      redirect = 1'b1;
      fl_d     = 1'b1;
      fl_e     = 1'b1;
    end else if (lu) begin
      st_f = 1'b1;
      st_d = 1'b1;
      fl_e = 1'b1;
    end

    fwd_a = fwd_sel(hz.rs1_addr_E, hz.rd_addr_M, hz.rd_wren_M, hz.rd_addr_W, hz.rd_wren_W);
    fwd_b = fwd_sel(hz.rs2_addr_E, hz.rd_addr_M, hz.rd_wren_M, hz.rd_addr_W, hz.rd_wren_W);

    stall_cnt_d = stall_cnt_q + {31'd0, st_f};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset masks every control output immediately, independent of the inputs.
  assign hz.stall_F      = st_f & ~i_rst;
  assign hz.stall_D      = st_d & ~i_rst;
  assign hz.stall_E      = st_e & ~i_rst;
  assign hz.stall_M      = st_m & ~i_rst;
  assign hz.flush_D      = fl_d & ~i_rst;
  assign hz.flush_E      = fl_e & ~i_rst;
  assign hz.flush_W      = fl_w & ~i_rst;
  assign hz.err_timeout  = timeout_rel & ~i_rst;
  assign hz.fwd_a_E      = i_rst ? 2'b00 : fwd_a;
  assign hz.fwd_b_E      = i_rst ? 2'b00 : fwd_b;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (TIMEOUT=4): per-cycle expected controls queued at drive time, compared at negedge.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       wrE, wrM, wrW;
    logic [1:0] wbE;
    logic       pc, req, ack;
  } stim_t;

  // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W,err_timeout,fwd_a,fwd_b}
  localparam logic [11:0] NONE  = 12'h000;
  localparam logic [11:0] MEMST = 12'hF20;
  localparam logic [11:0] LU    = 12'hC40;
  localparam logic [11:0] REDIR = 12'h0C0;
  localparam logic [11:0] TOUT  = 12'h010;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.WB_MEM(2'b01), .TIMEOUT(8'd4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .hz    (hif)
  );

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  function automatic logic [11:0] obs();
    return {hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M, hif.flush_D, hif.flush_E,
            hif.flush_W, hif.err_timeout, hif.fwd_a_E, hif.fwd_b_E};
  endfunction

  function automatic stim_t st_lu(input logic [4:0] rs1D, input logic [4:0] rs2D,
                                  input logic [4:0] rdE, input logic wr, input logic [1:0] wb,
                                  input logic pc);
    stim_t s = '0;
    s.rs1D = rs1D; s.rs2D = rs2D; s.rdE = rdE; s.wrE = wr; s.wbE = wb; s.pc = pc;
    return s;
  endfunction

  function automatic stim_t st_mem(input logic req, input logic ack, input logic pc);
    stim_t s = '0;
    s.req = req; s.ack = ack; s.pc = pc;
    return s;
  endfunction

  function automatic stim_t st_fwd(input logic [4:0] rdM, input logic wrM, input logic [4:0] rdW,
                                   input logic wrW, input logic [4:0] rs1E, input logic [4:0] rs2E,
                                   input logic req, input logic ack);
    stim_t s = '0;
    s.rdM = rdM; s.wrM = wrM; s.rdW = rdW; s.wrW = wrW;
    s.rs1E = rs1E; s.rs2E = rs2E; s.req = req; s.ack = ack;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hif.rs1_addr_D = s.rs1D; hif.rs2_addr_D = s.rs2D;
    hif.rs1_addr_E = s.rs1E; hif.rs2_addr_E = s.rs2E;
    hif.rd_addr_E  = s.rdE;  hif.rd_addr_M  = s.rdM;  hif.rd_addr_W = s.rdW;
    hif.rd_wren_E  = s.wrE;  hif.rd_wren_M  = s.wrM;  hif.rd_wren_W = s.wrW;
    hif.wb_sel_E   = s.wbE;  hif.pc_sel_E   = s.pc;
    hif.mem_req_M  = s.req;  hif.mem_ack    = s.ack;
  endtask

  // Drive one cycle of stimulus and queue what the controller must show for it.
  task automatic drive(input stim_t s, input logic [11:0] e);
    apply(s);
    exp_q.push_back(e);
    if (e[11]) exp_stall++;
    if (e[7])  exp_flush++;
  endtask

  task automatic test_reset();
    stim_t s;
    logic [11:0] got, e;
    s = st_fwd(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b1, 1'b0);
    s.rs1D = 5'd5; s.rdE = 5'd5; s.wrE = 1'b1; s.wbE = 2'b01; s.pc = 1'b1;
    drive(s, NONE);
    @(negedge i_clk);
    got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", got, e); end
    checks++;
    if (hif.stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got=%0d exp=0", hif.stall_cycles); end
    checks++;
    if (hif.flush_events !== 32'd0) begin errors++; $display("FAIL reset_flush_events got=%0d exp=0", hif.flush_events); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    drive('0, NONE);
    @(negedge i_clk);
    got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_release_idle got=%h exp=%h", got, e); end
    @(posedge i_clk); #1;
  endtask

  task automatic run_table(input string name, input stim_t sq[$], input logic [11:0] eq[$]);
    logic [11:0] got, e;
    for (int i = 0; i < sq.size(); i++) begin
      drive(sq[i], eq[i]);
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL %s[%0d] got=%h exp=%h", name, i, got, e); end
      @(posedge i_clk); #1;
    end
    apply('0);
    @(negedge i_clk);
    checks++;
    if (hif.stall_cycles !== exp_stall) begin
      errors++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, hif.stall_cycles, exp_stall);
    end
    checks++;
    if (hif.flush_events !== exp_flush) begin
      errors++; $display("FAIL %s_flush_events got=%0d exp=%0d", name, hif.flush_events, exp_flush);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_load_use();
    stim_t sq[$]; logic [11:0] eq[$];
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0)); eq.push_back(LU);
    sq.push_back('0);                                          eq.push_back(NONE);
    sq.push_back(st_lu(5'd0, 5'd9, 5'd9, 1'b1, 2'b01, 1'b0)); eq.push_back(LU);
    sq.push_back(st_lu(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b0, 2'b01, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_lu(5'd4, 5'd6, 5'd5, 1'b1, 2'b01, 1'b0)); eq.push_back(NONE);
    run_table("load_use", sq, eq);
  endtask

  task automatic test_redirect();
    stim_t sq[$]; logic [11:0] eq[$];
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1)); eq.push_back(REDIR);
    sq.push_back('0);                                          eq.push_back(NONE);
    sq.push_back(st_lu(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1)); eq.push_back(REDIR);
    run_table("redirect", sq, eq);
  endtask

  task automatic test_mem_wait();
    stim_t sq[$]; logic [11:0] eq[$];
    for (int i = 0; i < 3; i++) begin sq.push_back(st_mem(1'b1, 1'b0, 1'b0)); eq.push_back(MEMST); end
    sq.push_back(st_mem(1'b1, 1'b1, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_mem(1'b0, 1'b0, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_mem(1'b1, 1'b1, 1'b0)); eq.push_back(NONE);
    sq.push_back(st_mem(1'b1, 1'b0, 1'b1)); eq.push_back(MEMST);
    sq.push_back(st_mem(1'b1, 1'b1, 1'b1)); eq.push_back(REDIR);
    run_table("mem_wait", sq, eq);
  endtask

  task automatic test_timeout();
    stim_t sq[$]; logic [11:0] eq[$];
    for (int i = 0; i < 5; i++) begin sq.push_back(st_mem(1'b1, 1'b0, 1'b0)); eq.push_back(MEMST); end
    sq.push_back(st_mem(1'b1, 1'b0, 1'b0)); eq.push_back(TOUT);
    sq.push_back(st_mem(1'b0, 1'b0, 1'b0)); eq.push_back(NONE);
    run_table("timeout", sq, eq);
  endtask

  task automatic test_forwarding();
    stim_t sq[$]; logic [11:0] eq[$];
    sq.push_back(st_fwd(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0)); eq.push_back(12'h00A);
    sq.push_back(st_fwd(5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0)); eq.push_back(12'h005);
    sq.push_back(st_fwd(5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd0, 1'b0, 1'b0)); eq.push_back(12'h004);
    sq.push_back(st_fwd(5'd3, 1'b1, 5'd7, 1'b1, 5'd3, 5'd7, 1'b0, 1'b0)); eq.push_back(12'h009);
    sq.push_back(st_fwd(5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 1'b0, 1'b0)); eq.push_back(12'h005);
    sq.push_back(st_fwd(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0)); eq.push_back(12'h000);
    sq.push_back(st_fwd(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b1, 1'b0)); eq.push_back(12'hF2A);
    sq.push_back(st_fwd(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b1, 1'b1)); eq.push_back(12'h00A);
    run_table("forwarding", sq, eq);
  endtask

  task automatic test_back_to_back();
    stim_t sq[$]; logic [11:0] eq[$];
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0)); eq.push_back(LU);
    sq.push_back(st_lu(5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b1)); eq.push_back(REDIR);
    sq.push_back(st_lu(5'd0, 5'd6, 5'd6, 1'b1, 2'b01, 1'b0)); eq.push_back(LU);
    sq.push_back(st_mem(1'b1, 1'b0, 1'b0));                  eq.push_back(MEMST);
    sq.push_back(st_mem(1'b1, 1'b1, 1'b0));                  eq.push_back(NONE);
    run_table("back_to_back", sq, eq);
  endtask

  task automatic test_reset_mid_wait();
    stim_t s;
    logic [11:0] got, e;
    for (int i = 0; i < 2; i++) begin
      drive(st_mem(1'b1, 1'b0, 1'b0), MEMST);
      @(negedge i_clk);
      got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL rst_wait_pre[%0d] got=%h exp=%h", i, got, e); end
      @(posedge i_clk); #1;
    end
    s = st_fwd(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b1, 1'b0);
    s.pc = 1'b1;
    i_rst = 1'b1;
    drive(s, NONE);
    exp_stall = 0; exp_flush = 0;
    @(negedge i_clk);
    got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_wait_outputs got=%h exp=%h", got, e); end
    checks++;
    if (hif.stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_wait_stall_cycles got=%0d exp=0", hif.stall_cycles); end
    checks++;
    if (hif.flush_events !== 32'd0) begin errors++; $display("FAIL rst_wait_flush_events got=%0d exp=0", hif.flush_events); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    // Back in RUN: a redirect must fire even with ack still low.
    drive(st_mem(1'b0, 1'b0, 1'b1), REDIR);
    @(negedge i_clk);
    got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL rst_wait_first_run got=%h exp=%h", got, e); end
    @(posedge i_clk); #1;
    apply('0);
    @(negedge i_clk);
    checks++;
    if (hif.flush_events !== exp_flush) begin
      errors++; $display("FAIL rst_wait_flush_after got=%0d exp=%0d", hif.flush_events, exp_flush);
    end
    checks++;
    if (hif.stall_cycles !== exp_stall) begin
      errors++; $display("FAIL rst_wait_stall_after got=%0d exp=%0d", hif.stall_cycles, exp_stall);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    apply('0);
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
